// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: fetch FSM encoding, register-zero
// constant and legal ranges for the fetch-control parameters.
package fetch_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int CNT_W            = 3;
    localparam int MEM_WAIT_MIN     = 0;
    localparam int MEM_WAIT_MAX     = 7;
    localparam int FLUSH_CYCLES_MIN = 1;
    localparam int FLUSH_CYCLES_MAX = 3;

endpackage

// File: rtl/fetch_hazard_ctrl_load_use.sv
// Combinational load-use compare, shared with the ID stage: a load in ID_EX
// whose destination feeds either source of the instruction in IF_ID.
module load_use_detect
    import fetch_hazard_ctrl_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       lu
);

    // Register zero never carries a dependency.
    assign lu = mem_read && (ex_rt != REG_ZERO) &&
                ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage hazard/flush/bubble control with instruction-memory wait states.
// Optional FETCH_PERF_EN adds saturating stall/flush cycle counters.
module fetch_hazard_ctrl
    import fetch_hazard_ctrl_pkg::*;
#(
    parameter int MEM_WAIT     = 0,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_EX_memRead,
    input  logic [4:0]  ID_EX_rt,
    input  logic [4:0]  IF_ID_rs,
    input  logic [4:0]  IF_ID_rt,
    input  logic        EX_MEM_select,
    output logic        hazard,
    output logic        flush,
    output logic        bubble,
    output logic        fetch_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    generate
        if (MEM_WAIT < MEM_WAIT_MIN || MEM_WAIT > MEM_WAIT_MAX) begin : g_bad_mem_wait
            $error("fetch_hazard_ctrl: MEM_WAIT out of range 0..7");
        end
        if (FLUSH_CYCLES < FLUSH_CYCLES_MIN || FLUSH_CYCLES > FLUSH_CYCLES_MAX) begin : g_bad_flush
            $error("fetch_hazard_ctrl: FLUSH_CYCLES out of range 1..3");
        end
    endgenerate

    localparam logic [CNT_W-1:0] WAIT_INIT  = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam bit               HAS_WAIT   = (MEM_WAIT > 0);
    localparam bit               HAS_FLUSH  = (FLUSH_CYCLES > 1);

    fetch_state_t     state, state_n;
    logic [CNT_W-1:0] flush_cnt, flush_cnt_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic             lu;

    load_use_detect u_lu (
        .mem_read (ID_EX_memRead),
        .ex_rt    (ID_EX_rt),
        .id_rs    (IF_ID_rs),
        .id_rt    (IF_ID_rt),
        .lu       (lu)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
            wait_cnt  <= wait_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        wait_cnt_n  = wait_cnt;
        hazard      = 1'b0;
        flush       = 1'b0;
        bubble      = 1'b0;
        fetch_valid = 1'b0;
        if (reset) begin
            state_n     = RUN;
            flush_cnt_n = '0;
            wait_cnt_n  = '0;
        end else if (EX_MEM_select) begin
            // A redirect restarts the flush/wait sequence from any state.
            flush       = 1'b1;
            flush_cnt_n = '0;
            wait_cnt_n  = '0;
            if (HAS_FLUSH) begin
                state_n     = FLUSH;
                flush_cnt_n = FLUSH_INIT;
            end else if (HAS_WAIT) begin
                state_n    = WAIT;
                wait_cnt_n = WAIT_INIT;
            end else begin
                state_n = RUN;
            end
        end else begin
            unique case (state)
                FLUSH: begin
                    flush = 1'b1;
                    if (flush_cnt <= CNT_W'(1)) begin
                        flush_cnt_n = '0;
                        if (HAS_WAIT) begin
                            state_n    = WAIT;
                            wait_cnt_n = WAIT_INIT;
                        end else begin
                            state_n = RUN;
                        end
                    end else begin
                        flush_cnt_n = flush_cnt - CNT_W'(1);
                    end
                end
                WAIT: begin
                    hazard = 1'b1;
                    bubble = lu;
                    if (wait_cnt <= CNT_W'(1)) begin
                        state_n    = RUN;
                        wait_cnt_n = '0;
                    end else begin
                        wait_cnt_n = wait_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    // One-cycle stall: next cycle ID_EX holds the bubble, so lu clears.
                    if (lu) begin
                        hazard = 1'b1;
                        bubble = 1'b1;
                    end else begin
                        fetch_valid = 1'b1;
                        if (HAS_WAIT) begin
                            state_n    = WAIT;
                            wait_cnt_n = WAIT_INIT;
                        end
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (hazard && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (flush && (flush_cycles != 32'hFFFF_FFFF))
                flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule
